// File: rtl/op_issue.sv
// Operand issue stage: queues secret operand pairs in a DEPTH-entry FIFO and issues
// them one per cycle, inserting DRAIN_CYCLES bubbles whenever the requested mode changes.
// Ports: clk/rst_n; in_valid/in_ready/in_opa/in_opb/in_fast upstream handshake;
// flush discards the queue; issue_valid/issue_opa/issue_opb/issue_fast registered downstream.
// All control depends only on valid/mode/flush and internal state, never on operand values.
module op_issue #(
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_opa,
  input  logic [31:0] in_opb,
  input  logic        in_fast,
  input  logic        flush,
  output logic        issue_valid,
  output logic [31:0] issue_opa,
  output logic [31:0] issue_opb,
  output logic        issue_fast
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic {RUN, DRAIN} state_t;

  logic [31:0]      mem_a [DEPTH];
  logic [31:0]      mem_b [DEPTH];
  logic [DEPTH-1:0] mem_f;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic [CW-1:0] drain_cnt;
  logic          last_fast;

  logic full;
  logic empty;
  logic head_fast;
  logic push;
  logic pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_fast = mem_f[rd_ptr];
  assign in_ready  = !full && !flush;
  assign push      = in_valid && in_ready;

  // Pop decision looks only at the head's mode bit, so issue timing never
  // depends on operand values.
  always_comb begin
    pop = 1'b0;
    if (!flush && !empty) begin
      case (state)
        RUN:   pop = (head_fast == last_fast);
        DRAIN: pop = (drain_cnt == '0);
        default: pop = 1'b0;
      endcase
    end
  end

  // Storage needs no reset: entries are only ever exposed alongside issue_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_opa;
      mem_b[wr_ptr] <= in_opb;
      mem_f[wr_ptr] <= in_fast;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      state       <= RUN;
      drain_cnt   <= '0;
      last_fast   <= 1'b0;
      issue_valid <= 1'b0;
      issue_opa   <= '0;
      issue_opb   <= '0;
      issue_fast  <= 1'b0;
    end else if (flush) begin
      // Flush wins over any push/pop this cycle; the current mode survives.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      state       <= RUN;
      drain_cnt   <= '0;
      issue_valid <= 1'b0;
      issue_opa   <= '0;
      issue_opb   <= '0;
      issue_fast  <= last_fast;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      issue_valid <= pop;
      issue_opa   <= pop ? mem_a[rd_ptr] : 32'h0;
      issue_opb   <= pop ? mem_b[rd_ptr] : 32'h0;
      // Outside an issue, keep presenting the old mode so the downstream
      // fast path can retire its in-flight pair.
      issue_fast  <= pop ? head_fast : last_fast;
      if (pop) last_fast <= head_fast;

      case (state)
        RUN: begin
          if (!empty && (head_fast != last_fast)) begin
            state     <= DRAIN;
            drain_cnt <= CW'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= RUN;
          else                 drain_cnt <= drain_cnt - CW'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/op_issue.md
OP_ISSUE -- requirements
Module: op_issue

Interface
REQ-001 Parameter DEPTH, default 4, operand FIFO entries; power of two, at least 2.
REQ-002 Parameter DRAIN_CYCLES, default 1, bubble cycles inserted on a mode change; at least 1.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream offers an operand pair.
REQ-006 in_ready  output  1  block accepts the pair this cycle.
REQ-007 in_opa  input  32  operand A; secret, taint source.
REQ-008 in_opb  input  32  operand B; secret, taint source.
REQ-009 in_fast  input  1  requested mode for this pair; public.
REQ-010 flush  input  1  synchronous discard of all queued pairs.
REQ-011 issue_valid  output  1  issue_opa and issue_opb carry a pair this cycle.
REQ-012 issue_opa  output  32  operand A to the downstream combine stage.
REQ-013 issue_opb  output  32  operand B to the downstream combine stage.
REQ-014 issue_fast  output  1  mode enable to the downstream combine stage.

Function
REQ-015 Handshake: a transfer occurs on a posedge where in_valid=1 and in_ready=1.
REQ-016 in_ready is combinational: in_ready = !full && !flush.
REQ-017 A transfer writes {in_opa, in_opb, in_fast} into a FIFO of DEPTH entries.
REQ-018 The FIFO has binary read/write pointers that wrap modulo DEPTH and a count register from 0 to DEPTH.
REQ-019 If in_valid=1 while in_ready=0, nothing is stored and nothing changes.
REQ-020 No push when full, even if a pop occurs in the same cycle.
REQ-021 A push and a pop in the same cycle leave the count unchanged.
REQ-022 The block holds the register last_fast, the mode of the most recently issued pair; it resets to 0.
REQ-023 The FSM has two states: RUN and DRAIN.
REQ-024 RUN, FIFO non-empty, head.fast == last_fast:
  - pop the head;
  - register issue_valid=1, issue_opa/issue_opb = head operands, issue_fast = head.fast.
REQ-025 RUN, FIFO non-empty, head.fast != last_fast:
  - no pop; register issue_valid=0;
  - load drain_cnt = DRAIN_CYCLES-1; go to DRAIN.
REQ-026 RUN, FIFO empty: register issue_valid=0.
REQ-027 DRAIN:
  - issue_valid=0 and issue_fast=last_fast, so the downstream fast path retires its in-flight pair;
  - decrement drain_cnt each cycle;
  - at drain_cnt==0, go to RUN, set last_fast=head.fast, and pop/issue the head the same cycle.
REQ-028 Whenever issue_valid=0, issue_opa and issue_opb SHALL be 32'h0; no secret value is visible without valid.
REQ-029 While not issuing, issue_fast holds last_fast.
REQ-030 Latency: a pair accepted at edge k appears on issue_* after edge k+1 at the earliest; throughput is one pair per cycle within a mode.
REQ-031 Constant-time: every control signal depends only on in_valid, in_fast, flush, rst_n and internal state, never on in_opa or in_opb:
  - in_ready, issue_valid, issue_fast, FSM state, pointers and count;
  - issue timing is independent of operand values.
REQ-032 flush=1 at a posedge:
  - clears pointers and count, forces state RUN and issue_valid=0, zeroes the issue operands;
  - keeps last_fast;
  - flush takes priority over a push and a pop in the same cycle.

Reset
REQ-033 rst_n=0 asynchronously sets:
  - count=0, pointers=0, state=RUN, drain_cnt=0, last_fast=0;
  - issue_valid=0, issue_opa=0, issue_opb=0, issue_fast=0.
REQ-034 Reset mid-operation discards all queued pairs and any drain in progress.
REQ-035 in_ready=1 from the first cycle rst_n=1.
REQ-036 FIFO storage contents need no reset; they are never visible because of REQ-028.

Verification
REQ-037 Reset, then push A=0x11111111/B=0x22222222, fast=0 at edge 1 -> issue_valid=1 with those operands and issue_fast=0 after edge 2; zeros before.
REQ-038 Push 4 pairs with fast=0 while downstream issuing is stalled by a mode change at the head -> in_ready=0 at count=4; a 5th in_valid is ignored; count stays 4.
REQ-039 Push fast=0 pair, then fast=1 pair, DRAIN_CYCLES=1 -> first issued; then one cycle issue_valid=0 with issue_fast=0; then second issued with issue_fast=1.
REQ-040 Two runs with identical in_valid/in_fast/flush sequences and differing random operands -> cycle-identical in_ready, issue_valid, issue_fast traces.
REQ-041 flush asserted with in_valid=1 and 3 entries queued -> count=0, next issue_valid=0, pushed pair dropped, last_fast unchanged.
REQ-042 rst_n pulled low mid-DRAIN, between edges -> all outputs zero immediately; after release the first pair issues without a drain if fast=0.
